// File: rtl/arm_emit_buffer.sv
// rtl/arm_emit_buffer.sv - FIFO-buffered sink draining translated ARM words into code RAM
module arm_emit_buffer #(
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           data,
    input  logic                  start,
    output logic                  ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  mem_we,
    input  logic                  mem_ack,
    output logic [ADDR_WIDTH-2:0] words_written,
    output logic                  drained,
    output logic                  wrapped
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    logic [31:0]           fifo_q [DEPTH];
    logic [31:0]           fifo_d [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [ADDR_WIDTH-2:0] ww_q, ww_d;
    logic                  wrapped_q, wrapped_d;

    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH:0]   addr_inc;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign push     = start && !full;
    // Extra top bit carries out of the address space to detect a wrap.
    assign addr_inc = {1'b0, addr_q} + (ADDR_WIDTH + 1)'(4);

    assign ready         = !full;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign mem_we        = (state_q == WRITE);
    assign words_written = ww_q;
    assign wrapped       = wrapped_q;
    // Built only from registered state, so a same-cycle push cannot glitch it.
    assign drained       = empty && (state_q == IDLE);

    // Push side: store the offered word and advance the write pointer.
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        if (push) begin
            fifo_d[wr_ptr_q] = data;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
    end

    // Occupancy tracking; a simultaneous push and pop cancel out.
    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Drain FSM: pop the head into the write port and advance on each ack.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        ww_d      = ww_q;
        wrapped_d = wrapped_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    wdata_d = fifo_q[rd_ptr_q];
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    addr_d = addr_inc[ADDR_WIDTH-1:0];
                    ww_d   = ww_q + (ADDR_WIDTH - 1)'(1);
                    if (addr_inc[ADDR_WIDTH]) begin
                        wrapped_d = 1'b1;
                    end
                    if (!empty) begin
                        pop     = 1'b1;
                        wdata_d = fifo_q[rd_ptr_q];
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO storage; contents are only read after being written, so no reset.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    // Control and write-port registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= IDLE;
            addr_q    <= ADDR_WIDTH'(BASE_ADDR);
            wdata_q   <= '0;
            ww_q      <= '0;
            wrapped_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ww_q      <= ww_d;
            wrapped_q <= wrapped_d;
        end
    end

endmodule

// File: tb/tb_arm_emit_buffer.sv
// tb/tb_arm_emit_buffer.sv - directed self-checking bench for arm_emit_buffer
module tb_arm_emit_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data = '0;
    logic        start = 1'b0;
    logic        ready;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_ack = 1'b0;
    logic [14:0] words_written;
    logic        drained;
    logic        wrapped;

    logic [31:0] w_data = '0;
    logic        w_start = 1'b0;
    logic        w_ready;
    logic [3:0]  w_addr;
    logic [31:0] w_wdata;
    logic        w_we;
    logic        w_ack = 1'b0;
    logic [2:0]  w_ww;
    logic        w_drained;
    logic        w_wrapped;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];

    arm_emit_buffer #(.DEPTH(8), .ADDR_WIDTH(16), .BASE_ADDR(0)) dut (
        .clk(clk), .reset(reset), .data(data), .start(start), .ready(ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_ack(mem_ack),
        .words_written(words_written), .drained(drained), .wrapped(wrapped)
    );

    arm_emit_buffer #(.DEPTH(8), .ADDR_WIDTH(4), .BASE_ADDR(12)) u_wrap (
        .clk(clk), .reset(reset), .data(w_data), .start(w_start), .ready(w_ready),
        .mem_addr(w_addr), .mem_wdata(w_wdata), .mem_we(w_we), .mem_ack(w_ack),
        .words_written(w_ww), .drained(w_drained), .wrapped(w_wrapped)
    );

    always #5 clk = ~clk;

    // Record every completed write on the main instance.
    always @(posedge clk) begin
        if (!reset && mem_we && mem_ack) begin
            log_addr.push_back({16'h0, mem_addr});
            log_data.push_back(mem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        start   = 1'b0;
        mem_ack = 1'b0;
        w_start = 1'b0;
        w_ack   = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic wait_drained(input string tag);
        for (int i = 0; i < 100; i++) begin
            if (drained) break;
            tick();
        end
        check(tag, {31'h0, drained}, 32'h1);
    endtask

    task automatic check_log_entry(input string tag, input int idx,
                                   input logic [31:0] exp_addr, input logic [31:0] exp_data);
        if (idx < log_addr.size()) begin
            check({tag, "_addr"}, log_addr[idx], exp_addr);
            check({tag, "_data"}, log_data[idx], exp_data);
        end else begin
            check({tag, "_missing"}, 32'h0, 32'h1);
        end
    endtask

    initial begin
        int pushed;
        int stab_err;
        logic prev_we, prev_ack, accepted;
        logic [15:0] prev_addr;
        logic [31:0] prev_wdata;

        do_reset();
        check("rst_ready", {31'h0, ready}, 32'h1);
        check("rst_we", {31'h0, mem_we}, 32'h0);
        check("rst_addr", {16'h0, mem_addr}, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_ww", {17'h0, words_written}, 32'h0);
        check("rst_drained", {31'h0, drained}, 32'h1);
        check("rst_wrapped", {31'h0, wrapped}, 32'h0);
        check("rst_wrap_addr", {28'h0, w_addr}, 32'hC);

        // Single word with ack tied high.
        mem_ack = 1'b1;
        data = 32'hE3A00005;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t1_no_bypass", {31'h0, mem_we}, 32'h0);
        tick();
        check("t1_we", {31'h0, mem_we}, 32'h1);
        check("t1_addr", {16'h0, mem_addr}, 32'h0);
        check("t1_wdata", mem_wdata, 32'hE3A00005);
        tick();
        check("t1_ww", {17'h0, words_written}, 32'h1);
        check("t1_addr_next", {16'h0, mem_addr}, 32'h4);
        check("t1_drained", {31'h0, drained}, 32'h1);

        // Backpressure fill: 9 captures fill the buffer, the 10th stalls.
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            data = i;
            start = 1'b1;
            check($sformatf("t2_ready_%0d", i), {31'h0, ready}, 32'h1);
            tick();
        end
        data = 32'hA;
        check("t2_full", {31'h0, ready}, 32'h0);
        repeat (3) tick();
        check("t2_stall", {31'h0, ready}, 32'h0);
        check("t2_hold_addr", {16'h0, mem_addr}, 32'h0);
        check("t2_hold_wdata", mem_wdata, 32'h1);
        mem_ack = 1'b1;
        tick();
        check("t2_ready_after_ack", {31'h0, ready}, 32'h1);
        tick();
        start = 1'b0;
        wait_drained("t2_drain");
        check("t2_count", log_addr.size(), 32'd10);
        for (int i = 0; i < 10; i++) begin
            check_log_entry($sformatf("t2_w%0d", i), i, i * 4, i + 1);
        end
        check("t2_ww", {17'h0, words_written}, 32'd10);

        // Push held while full and ack arrives on the same edge.
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            data = 32'h100 + i;
            start = 1'b1;
            tick();
        end
        data = 32'hE52D0004;
        mem_ack = 1'b1;
        check("t3_ready_on_ack", {31'h0, ready}, 32'h0);
        tick();
        check("t3_ready_next", {31'h0, ready}, 32'h1);
        tick();
        start = 1'b0;
        wait_drained("t3_drain");
        check("t3_count", log_addr.size(), 32'd10);
        for (int i = 0; i < 9; i++) begin
            check_log_entry($sformatf("t3_w%0d", i), i, i * 4, 32'h101 + i);
        end
        check_log_entry("t3_last", 9, 32'h24, 32'hE52D0004);

        // Wait states: ack every third cycle.
        do_reset();
        pushed = 0;
        stab_err = 0;
        prev_we = 1'b0;
        prev_ack = 1'b0;
        prev_addr = '0;
        prev_wdata = '0;
        data = 32'hE3400007;
        for (int c = 0; c < 80; c++) begin
            mem_ack = (c % 3 == 2);
            start = (pushed < 4);
            if (prev_we && !prev_ack &&
                (mem_we !== 1'b1 || mem_addr !== prev_addr || mem_wdata !== prev_wdata))
                stab_err++;
            prev_we = mem_we;
            prev_ack = mem_ack;
            prev_addr = mem_addr;
            prev_wdata = mem_wdata;
            accepted = start && ready;
            tick();
            if (accepted) pushed++;
            if (pushed == 4 && drained) break;
        end
        start = 1'b0;
        check("t4_pushed", pushed, 32'd4);
        check("t4_stable", stab_err, 32'd0);
        check("t4_drained", {31'h0, drained}, 32'h1);
        check("t4_count", log_addr.size(), 32'd4);
        check("t4_ww", {17'h0, words_written}, 32'd4);
        for (int i = 0; i < 4; i++) begin
            check_log_entry($sformatf("t4_w%0d", i), i, i * 4, 32'hE3400007);
        end

        // Wrap on the small-address instance.
        do_reset();
        w_ack = 1'b1;
        w_start = 1'b1;
        w_data = 32'hAAAA0001;
        tick();
        w_data = 32'hBBBB0002;
        tick();
        w_start = 1'b0;
        check("t5_addr0", {28'h0, w_addr}, 32'hC);
        check("t5_data0", w_wdata, 32'hAAAA0001);
        check("t5_no_wrap_yet", {31'h0, w_wrapped}, 32'h0);
        tick();
        check("t5_addr1", {28'h0, w_addr}, 32'h0);
        check("t5_data1", w_wdata, 32'hBBBB0002);
        check("t5_wrapped", {31'h0, w_wrapped}, 32'h1);
        tick();
        check("t5_ww", {29'h0, w_ww}, 32'd2);
        check("t5_wrapped_sticky", {31'h0, w_wrapped}, 32'h1);
        check("t5_drained", {31'h0, w_drained}, 32'h1);
        w_ack = 1'b0;

        // Reset in the middle of a pending write with words buffered.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            data = 32'h200 + i;
            start = 1'b1;
            tick();
        end
        start = 1'b0;
        check("t6_we_pending", {31'h0, mem_we}, 32'h1);
        check("t6_not_drained", {31'h0, drained}, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_we", {31'h0, mem_we}, 32'h0);
        check("t6_async_ready", {31'h0, ready}, 32'h1);
        log_addr.delete();
        log_data.delete();
        mem_ack = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        check("t6_addr", {16'h0, mem_addr}, 32'h0);
        check("t6_ww", {17'h0, words_written}, 32'h0);
        check("t6_drained", {31'h0, drained}, 32'h1);
        repeat (5) tick();
        check("t6_no_stale_we", {31'h0, mem_we}, 32'h0);
        check("t6_no_stale_write", log_addr.size(), 32'd0);
        check("t6_ww_after", {17'h0, words_written}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arm_emit_buffer.md
Name: arm_emit_buffer

Overview:
- Downstream sink for translated ARM instructions, taking the place of the single-entry writer.
- Accepts 32-bit ARM words on a start/ready handshake and buffers them in a small FIFO.
- Drains them in order into the output code RAM through a request/acknowledge write port, generating sequential byte addresses.
- Decouples translator stalls from code-RAM write latency, so the translator stalls only when the FIFO is full.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 2.
- ADDR_WIDTH, 16, code-RAM byte-address width.
- BASE_ADDR, 0, byte address of the first emitted word after reset; must be a multiple of 4.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- data  input  32  ARM instruction from the translator.
- start  input  1  translator offers data this cycle.
- ready  output  1  buffer can accept a word this cycle.
- mem_addr  output  ADDR_WIDTH  byte address of the current write.
- mem_wdata  output  32  word being written.
- mem_we  output  1  write request; held until acknowledged.
- mem_ack  input  1  code RAM accepted the write this cycle.
- words_written  output  ADDR_WIDTH-1  count of completed RAM writes.
- drained  output  1  FIFO empty and no write in flight.
- wrapped  output  1  sticky: mem_addr has wrapped past the top of the address space.

Behaviour:
- Reset, applied asynchronously:
  - FIFO empty; write/read pointers 0.
  - ready=1, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0.
  - words_written=0, drained=1, wrapped=0, FSM in IDLE.
- Push side:
  - ready = !full, combinational from registered occupancy.
  - A word is captured when start && ready at a clock edge.
  - start while ready=0 is ignored and nothing is captured; the translator holds start and data until accepted.
- Occupancy:
  - Counter 0..DEPTH.
  - full = (occupancy==DEPTH); empty = (occupancy==0).
  - Push and pop on the same edge leave occupancy unchanged. This is legal when full: ready stays 0 that cycle, so no push occurs.
  - A push into an empty FIFO is not visible to the drain side until the next cycle; no bypass.
- Drain FSM, states IDLE and WRITE:
  - IDLE: if !empty, load mem_wdata from FIFO head, pop, assert mem_we, go to WRITE. Otherwise stay in IDLE with mem_we=0.
  - WRITE: mem_we=1; mem_addr and mem_wdata held stable. When mem_ack=1 at an edge:
    - mem_addr <= mem_addr+4, modulo 2^ADDR_WIDTH.
    - words_written <= words_written+1, wrapping.
    - If the FIFO is non-empty, load the next head, pop, and stay in WRITE (back-to-back, no bubble). Otherwise drop mem_we and go to IDLE.
  - mem_ack outside WRITE is ignored.
- Latency and throughput:
  - Minimum latency from capture edge to mem_we=1 with that word is 1 cycle.
  - Sustained throughput is one word per cycle when mem_ack is tied high.
- Wrap:
  - When mem_addr+4 overflows ADDR_WIDTH, wrapped sets and stays set until reset.
  - Writing continues from address 0.
- drained = empty && state==IDLE, registered-equivalent (no glitch on a same-cycle push).
- Reset mid-write: mem_we drops immediately (asynchronously), buffered words are discarded, and addressing restarts at BASE_ADDR. A mem_ack arriving while reset is high has no effect.
- X-safety: mem_wdata and mem_addr only change on a pop or on an acknowledged write.

Test Plan:
- Single word: after reset, push 0xE3A00005 with mem_ack tied 1. Required: mem_we=1, mem_addr=0x0000, mem_wdata=0xE3A00005 in the cycle after capture; then words_written=1, mem_addr=0x0004, drained=1.
- Backpressure fill: mem_ack held 0, push 10 words 0x1..0xA. Required: ready drops after the 9th capture (8 in FIFO plus 1 in WRITE); words 10 onward stall. Release mem_ack: all 10 words appear in order at addresses 0x00..0x24, and ready reasserts after the first ack.
- Simultaneous push/pop when full: FIFO full, ack 1, start held with 0xE52D0004. Required: no capture on the ack edge (ready=0), capture on the following edge, no word lost or duplicated, order preserved.
- Wait states: mem_ack pulses every 3rd cycle during 4 pushes of 0xE3400007. Required: mem_addr and mem_wdata constant while mem_we=1 and ack=0; exactly 4 writes complete.
- Wrap: ADDR_WIDTH=4, BASE_ADDR=0xC, push 2 words. Required: writes to 0xC then 0x0, and wrapped=1 after the first ack.
- Reset mid-operation: 3 words buffered and WRITE pending, assert reset. Required: mem_we=0 and ready=1 without a clock edge; after release mem_addr=BASE_ADDR, words_written=0, no stale write issued.
